// File: rtl/alu_issue_capture_if.sv
// rtl/alu_issue_capture_if.sv - request, ALU-side and result signals of the ALU issue/capture stage
interface alu_issue_capture_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_ctrl;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_cout;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_overflow;
  logic        out_cout;
  logic        out_illegal;
  logic        busy;

  // master: the capture stage itself; slave: the requester, the ALU and the result consumer
  modport master (
    input  in_valid, in_a, in_b, in_ctrl, alu_result, alu_zero, alu_overflow, alu_cout, out_ready,
    output in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_result, out_zero, out_overflow,
           out_cout, out_illegal, busy
  );

  modport slave (
    output in_valid, in_a, in_b, in_ctrl, alu_result, alu_zero, alu_overflow, alu_cout, out_ready,
    input  in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_result, out_zero, out_overflow,
           out_cout, out_illegal, busy
  );
endinterface

// File: rtl/alu_issue_capture.sv
// rtl/alu_issue_capture.sv - launches one op onto a ripple ALU, waits SETTLE_CYCLES, captures result
module alu_issue_capture #(
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_issue_capture_if.master  cap_io
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic             out_zero_q, out_zero_d;
  logic             out_overflow_q, out_overflow_d;
  logic             out_cout_q, out_cout_d;
  logic             out_illegal_q, out_illegal_d;
  logic             ready_core;
  logic             accept;

  // Reset gating of in_ready stays on the output path only, so rst_n never feeds flop data.
  assign ready_core = (state_q == IDLE) || ((state_q == HOLD) && cap_io.out_ready);
  assign accept     = cap_io.in_valid && ready_core;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_ctrl_d     = alu_ctrl_q;
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_zero_d     = out_zero_q;
    out_overflow_d = out_overflow_q;
    out_cout_d     = out_cout_q;
    out_illegal_d  = out_illegal_q;

    case (state_q)
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          out_result_d   = cap_io.alu_result;
          out_zero_d     = cap_io.alu_zero;
          out_overflow_d = cap_io.alu_overflow;
          out_cout_d     = cap_io.alu_cout;
          out_illegal_d  = 1'b0;
          out_valid_d    = 1'b1;
          state_d        = HOLD;
        end
      end
      HOLD: begin
        if (cap_io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    // An accept overrides the HOLD release above, giving back-to-back issue on one edge.
    if (accept) begin
      if (!cap_io.in_ctrl[2]) begin
        alu_a_d    = cap_io.in_a;
        alu_b_d    = cap_io.in_b;
        alu_ctrl_d = cap_io.in_ctrl;
        cnt_d      = CNT_LOAD;
        state_d    = SETTLE;
      end else begin
        out_result_d   = '0;
        out_zero_d     = 1'b0;
        out_overflow_d = 1'b0;
        out_cout_d     = 1'b0;
        out_illegal_d  = 1'b1;
        out_valid_d    = 1'b1;
        state_d        = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_ctrl_q     <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_zero_q     <= 1'b0;
      out_overflow_q <= 1'b0;
      out_cout_q     <= 1'b0;
      out_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_ctrl_q     <= alu_ctrl_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_zero_q     <= out_zero_d;
      out_overflow_q <= out_overflow_d;
      out_cout_q     <= out_cout_d;
      out_illegal_q  <= out_illegal_d;
    end
  end

  assign cap_io.in_ready     = rst_n && ready_core;
  assign cap_io.alu_a        = alu_a_q;
  assign cap_io.alu_b        = alu_b_q;
  assign cap_io.alu_ctrl     = alu_ctrl_q;
  assign cap_io.out_valid    = out_valid_q;
  assign cap_io.out_result   = out_result_q;
  assign cap_io.out_zero     = out_zero_q;
  assign cap_io.out_overflow = out_overflow_q;
  assign cap_io.out_cout     = out_cout_q;
  assign cap_io.out_illegal  = out_illegal_q;
  assign cap_io.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_alu_issue_capture.sv
// tb/tb_alu_issue_capture.sv - self-checking bench for alu_issue_capture with a behavioural ALU
module tb_alu_issue_capture;
  localparam int S = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_capture_if bus ();

  alu_issue_capture #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cap_io (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit rand_on     = 1'b0;
  logic [35:0] exp_q[$];

  // {result, zero, overflow, cout} from plain two's-complement arithmetic
  function automatic logic [34:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic        ov, co;
    s = '0; r = '0; ov = 1'b0; co = 1'b0;
    case (c)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b001: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'b010: r = a ^ b;
      3'b011: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {r, (r == 32'd0), ov, co};
  endfunction

  function automatic logic [35:0] exp_out(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    if (c[2]) return {32'd0, 3'b000, 1'b1};
    return {ref_alu(a, b, c), 1'b0};
  endfunction

  always_comb begin
    {bus.alu_result, bus.alu_zero, bus.alu_overflow, bus.alu_cout} = ref_alu(bus.alu_a, bus.alu_b, bus.alu_ctrl);
  end

  // Scoreboard for the randomized phase: pop on output handshake, push on accept.
  always @(negedge clk) begin
    if (rand_on) begin
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rand_unexpected_output: got %h, required no output", {bus.out_result, bus.out_zero, bus.out_overflow, bus.out_cout, bus.out_illegal});
        end else begin
          if ({bus.out_result, bus.out_zero, bus.out_overflow, bus.out_cout, bus.out_illegal} !== exp_q[0]) begin
            miscompares++;
            $display("FAIL rand_output: got %h, required %h", {bus.out_result, bus.out_zero, bus.out_overflow, bus.out_cout, bus.out_illegal}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(exp_out(bus.in_a, bus.in_b, bus.in_ctrl));
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_ctrl = c;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!bus.out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic pop_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1; bus.in_a = 32'h1234; bus.in_b = 32'h1; bus.in_ctrl = 3'b000; bus.out_ready = 1'b0;
    #2;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got in_ready/out_valid/busy=%b, required 000", {bus.in_ready, bus.out_valid, bus.busy});
    end
    vectors++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.out_result, bus.out_zero, bus.out_overflow, bus.out_cout, bus.out_illegal} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got alu_a=%h alu_b=%h out_result=%h illegal=%b, required all 0", bus.alu_a, bus.alu_b, bus.out_result, bus.out_illegal);
    end
    repeat (2) @(posedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_ops();
    logic [31:0] ta[5] = '{32'd2, 32'd5, 32'd2, 32'h7FFF_FFFF, 32'hF0F0_F0F0};
    logic [31:0] tb[5] = '{32'd5, 32'd5, 32'd5, 32'd1,         32'hFFFF_0000};
    logic [2:0]  tc[5] = '{3'b000, 3'b001, 3'b011, 3'b000, 3'b010};
    logic [35:0] te[5] = '{{32'd7, 4'b0000}, {32'd0, 4'b1010}, {32'd1, 4'b0000},
                           {32'h8000_0000, 4'b0100}, {32'h0F0F_F0F0, 4'b0000}};
    int edges;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_op(ta[i], tb[i], tc[i]);
      wait_valid(edges);
      vectors++;
      if (edges !== S) begin
        miscompares++;
        $display("FAIL op%0d_latency: got %0d edges, required %0d", i, edges, S);
      end
      vectors++;
      if ({bus.out_result, bus.out_zero, bus.out_overflow, bus.out_cout, bus.out_illegal} !== {te[i][35:4], te[i][3:1], 1'b0}) begin
        miscompares++;
        $display("FAIL op%0d_result: got res=%h z=%b v=%b c=%b ill=%b, required %h", i, bus.out_result, bus.out_zero, bus.out_overflow, bus.out_cout, bus.out_illegal, te[i]);
      end
      vectors++;
      if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== {ta[i], tb[i], tc[i]}) begin
        miscompares++;
        $display("FAIL op%0d_alu_inputs: got %h/%h/%b, required %h/%h/%b", i, bus.alu_a, bus.alu_b, bus.alu_ctrl, ta[i], tb[i], tc[i]);
      end
      pop_result();
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    start_op(32'd3, 32'd4, 3'b100);
    vectors++;
    if ({bus.out_valid, bus.out_illegal, bus.busy} !== 3'b111) begin
      miscompares++;
      $display("FAIL illegal_flags: got valid/illegal/busy=%b, required 111", {bus.out_valid, bus.out_illegal, bus.busy});
    end
    vectors++;
    if ({bus.out_result, bus.out_zero, bus.out_overflow, bus.out_cout} !== 35'd0) begin
      miscompares++;
      $display("FAIL illegal_result: got %h, required 0", bus.out_result);
    end
    vectors++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== {32'hF0F0_F0F0, 32'hFFFF_0000, 3'b010}) begin
      miscompares++;
      $display("FAIL illegal_alu_kept: got %h/%h/%b, required f0f0f0f0/ffff0000/010", bus.alu_a, bus.alu_b, bus.alu_ctrl);
    end
    pop_result();
    vectors++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL illegal_release: got valid/busy=%b, required 00", {bus.out_valid, bus.busy});
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    @(negedge clk);
    start_op(32'd10, 32'd20, 3'b000);
    wait_valid(edges);
    bus.in_valid = 1'b1; bus.in_b = 32'd1; bus.in_ctrl = 3'b000;
    for (int i = 0; i < 20; i++) begin
      bus.in_a = $urandom;
      @(posedge clk); #1;
      vectors++;
      if ({bus.out_valid, bus.out_result, bus.in_ready, bus.alu_a} !== {1'b1, 32'd30, 1'b0, 32'd10}) begin
        miscompares++;
        $display("FAIL backpressure_hold%0d: got valid=%b res=%0d in_ready=%b alu_a=%0d, required 1/30/0/10", i, bus.out_valid, bus.out_result, bus.in_ready, bus.alu_a);
      end
    end
    bus.in_a = 32'd100; bus.out_ready = 1'b1; #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready: got %b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.busy, bus.alu_a} !== {1'b0, 1'b1, 32'd100}) begin
      miscompares++;
      $display("FAIL b2b_accept: got valid=%b busy=%b alu_a=%0d, required 0/1/100", bus.out_valid, bus.busy, bus.alu_a);
    end
    wait_valid(edges);
    vectors++;
    if ({edges[7:0], bus.out_result} !== {8'(S), 32'd101}) begin
      miscompares++;
      $display("FAIL b2b_result: got %0d edges res=%0d, required %0d edges res=101", edges, bus.out_result, S);
    end
    pop_result();
  endtask

  task automatic test_reset_mid_op();
    int edges;
    @(negedge clk);
    start_op(32'd9, 32'd9, 3'b000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; #1;
    vectors++;
    if ({bus.out_valid, bus.busy, bus.in_ready, bus.alu_a} !== {3'b000, 32'd0}) begin
      miscompares++;
      $display("FAIL settle_reset: got valid=%b busy=%b in_ready=%b alu_a=%h, required 0/0/0/0", bus.out_valid, bus.busy, bus.in_ready, bus.alu_a);
    end
    @(negedge clk); rst_n = 1'b1;
    start_op(32'd1, 32'd1, 3'b000);
    wait_valid(edges);
    vectors++;
    if ({edges[7:0], bus.out_result} !== {8'(S), 32'd2}) begin
      miscompares++;
      $display("FAIL post_reset_op: got %0d edges res=%0d, required %0d edges res=2", edges, bus.out_result, S);
    end
    #2 rst_n = 1'b0; #1;
    vectors++;
    if ({bus.out_valid, bus.busy, bus.out_result} !== {2'b00, 32'd0}) begin
      miscompares++;
      $display("FAIL hold_reset: got valid=%b busy=%b res=%h, required 0/0/0", bus.out_valid, bus.busy, bus.out_result);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_random();
    int  w;
    bit  acc;
    logic [2:0] c;
    rand_on = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(3)) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(2) != 0);
        end
      end
      c = ($urandom_range(5) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3));
      bus.in_valid = 1'b1;
      bus.in_a = ($urandom_range(3) == 0) ? 32'h7FFF_FFFF : $urandom;
      bus.in_b = ($urandom_range(3) == 0) ? bus.in_a : $urandom;
      bus.in_ctrl = c;
      w = 0; acc = 1'b0;
      while (!acc && w < 200) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
        bus.out_ready = ($urandom_range(2) != 0);
        w++;
      end
      bus.in_valid = 1'b0;
      vectors++;
      if (!acc) begin
        miscompares++;
        $display("FAIL rand_accept%0d: no accept within %0d cycles, required accept", i, w);
      end
    end
    bus.out_ready = 1'b1;
    w = 0;
    while ((exp_q.size() != 0 || bus.busy) && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    rand_on = 1'b0;
    bus.out_ready = 1'b0;
    vectors++;
    if ({exp_q.size() == 0, bus.busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL rand_drain: got %0d pending busy=%b, required 0 pending busy=0", exp_q.size(), bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
